inst_fetch_queue: RTL and testbench



---
 rtl/inst_fetch_queue_pkg.sv | 13 +
 rtl/inst_fetch_queue_fetch_fifo.sv | 71 +++++++
 rtl/inst_fetch_queue.sv | 119 +++++++++++
 tb/tb_inst_fetch_queue.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_queue_pkg.sv
// Shared constants for the instruction fetch queue: default widths and
// reset/bubble values, plus the 2-bit fetch state encodings.
package inst_fetch_queue_pkg;

    localparam int unsigned IF_XLEN     = 32;
    localparam logic [31:0] IF_RESET_PC = 32'h8000_0000;
    localparam logic [31:0] IF_INST_NOP = 32'h0000_0013;

    localparam logic [1:0] IF_IDLE    = 2'd0;
    localparam logic [1:0] IF_WAIT    = 2'd1;
    localparam logic [1:0] IF_DISCARD = 2'd2;

endpackage

// File: rtl/inst_fetch_queue_fetch_fifo.sv
// Synchronous FIFO holding packed {pc, inst} entries for the fetch queue.
// Pointers carry an extra wrap bit so full and empty are distinguishable.
module fetch_fifo
    import inst_fetch_queue_pkg::*;
#(
    parameter int unsigned WIDTH = 2 * IF_XLEN,
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     clear_i,
    input  logic [WIDTH-1:0]         data_i,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic [WIDTH-1:0]         head_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign count_o = wr_ptr_q - rd_ptr_q;
    assign head_o  = mem_q[rd_ptr_q[PTR_W-1:0]];

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    always_comb begin
        do_pop   = pop_i && !empty_o;
        do_push  = push_i && (!full_o || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q[PTR_W-1:0]] = data_i;
                wr_ptr_d = wr_ptr_q + (PTR_W + 1)'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + (PTR_W + 1)'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/inst_fetch_queue.sv
// Instruction fetch stage: single-outstanding sequential fetcher feeding a
// small {pc, inst} FIFO whose head is presented to decode (NOP when empty).
module inst_fetch_queue
    import inst_fetch_queue_pkg::*;
#(
    parameter int unsigned     XLEN       = IF_XLEN,
    parameter logic [XLEN-1:0] RESET_PC   = IF_RESET_PC,
    parameter int unsigned     FIFO_DEPTH = 2,
    parameter logic [XLEN-1:0] NOP_INST   = IF_INST_NOP
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            stall_i,
    input  logic            flush_i,
    input  logic [XLEN-1:0] flush_pc_i,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] inst_o,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [XLEN-1:0] imem_rdata_i
);

    localparam int unsigned     CNT_W      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    logic [1:0]        state_q, state_d;
    logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0]   req_pc_q, req_pc_d;
    logic [XLEN-1:0]   fetch_addr;
    logic              pending;
    logic              push;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W-1:0]  occupancy;
    logic [2*XLEN-1:0] head;

    fetch_fifo #(
        .WIDTH (2 * XLEN),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .pop_i   (pop),
        .clear_i (flush_i),
        .data_i  ({req_pc_q, imem_rdata_i}),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count),
        .head_o  (head)
    );

    // Requests are gated by flush and reset so no grant can land in those cycles.
    always_comb begin
        fetch_addr  = fetch_pc_q & ALIGN_MASK;
        pending     = (state_q != IF_IDLE);
        occupancy   = fifo_count + CNT_W'(pending);
        imem_req_o  = (state_q == IF_IDLE) && !fifo_full &&
                      (occupancy < CNT_W'(FIFO_DEPTH)) && !flush_i && !rst_i;
        imem_addr_o = fetch_addr;
        push        = (state_q == IF_WAIT) && imem_rvalid_i && !flush_i;
        pop         = !stall_i && !flush_i && !fifo_empty;

        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        case (state_q)
            IF_IDLE: begin
                if (imem_req_o && imem_gnt_i) begin
                    state_d    = IF_WAIT;
                    req_pc_d   = fetch_addr;
                    fetch_pc_d = fetch_addr + XLEN'(4);
                end
            end
            // A response arriving with a flush closes the transaction here, so there is nothing left to discard.
            IF_WAIT: begin
                if (imem_rvalid_i) begin
                    state_d = IF_IDLE;
                end else if (flush_i) begin
                    state_d = IF_DISCARD;
                end
            end
            IF_DISCARD: begin
                if (imem_rvalid_i) begin
                    state_d = IF_IDLE;
                end
            end
            default: state_d = IF_IDLE;
        endcase
        if (flush_i) begin
            fetch_pc_d = flush_pc_i & ALIGN_MASK;
        end

        if (fifo_empty) begin
            inst_o = NOP_INST;
            pc_o   = (state_q == IF_WAIT) ? req_pc_q : fetch_addr;
        end else begin
            pc_o   = head[2*XLEN-1:XLEN];
            inst_o = head[XLEN-1:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IF_IDLE;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
        end
    end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Self-checking bench for inst_fetch_queue: cycle table for streaming/stall,
// directed flush/wrap/reset sequences, and a grant-order scoreboard.
module tb_inst_fetch_queue;

    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        stall_i = 1'b0;
    logic        flush_i = 1'b0;
    logic [31:0] flush_pc_i = '0;
    logic [31:0] pc_o;
    logic [31:0] inst_o;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i = 1'b1;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = '0;

    int checks = 0;
    int errors = 0;

    logic        hold_resp = 1'b0;
    logic        use_override = 1'b0;
    logic [31:0] override_data = '0;

    logic [63:0] exp_q[$];
    logic [63:0] sb_head;

    typedef struct {
        logic        stall;
        logic        req;
        logic [31:0] addr;
        logic [31:0] pc;
        logic [31:0] inst;
    } vec_t;

    vec_t vecs[$];

    always #5 clk_i = ~clk_i;

    inst_fetch_queue dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .stall_i       (stall_i),
        .flush_i       (flush_i),
        .flush_pc_i    (flush_pc_i),
        .pc_o          (pc_o),
        .inst_o        (inst_o),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i)
    );

    // Memory contents: top byte A5 guarantees no word ever equals the NOP bubble.
    function automatic logic [31:0] memData(input logic [31:0] a);
        return {8'hA5, a[23:0]};
    endfunction

    // Instruction memory model: one outstanding request, rvalid the cycle
    // after grant unless held; a reset drops any outstanding response.
    initial begin : memory_model
        logic        s_rst, s_gnt, s_hold, s_ovr, busy;
        logic [31:0] s_addr, s_ovr_data, pend_addr;
        busy = 1'b0;
        pend_addr = '0;
        forever begin
            @(negedge clk_i);
            s_rst      = rst_i;
            s_gnt      = imem_req_o && imem_gnt_i;
            s_addr     = imem_addr_o;
            s_hold     = hold_resp;
            s_ovr      = use_override;
            s_ovr_data = override_data;
            @(posedge clk_i);
            #1;
            if (s_rst) begin
                busy = 1'b0;
                imem_rvalid_i = 1'b0;
            end else begin
                if (imem_rvalid_i) begin
                    imem_rvalid_i = 1'b0;
                    busy = 1'b0;
                end
                if (s_gnt) begin
                    busy = 1'b1;
                    pend_addr = s_addr;
                end
                if (busy && !imem_rvalid_i && !s_hold) begin
                    imem_rvalid_i = 1'b1;
                    imem_rdata_i  = s_ovr ? s_ovr_data : memData(pend_addr);
                end
            end
        end
    end

    // Scoreboard: every grant queues the word it should eventually deliver;
    // flush and reset void everything queued; each decode pop is compared in order.
    always @(negedge clk_i) begin
        if (rst_i) begin
            exp_q.delete();
        end else begin
            if (!stall_i && !flush_i && inst_o != NOP) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL pop_order: presented pc=%h inst=%h, expected no instruction", pc_o, inst_o);
                end else begin
                    sb_head = exp_q.pop_front();
                    if ({pc_o, inst_o} !== sb_head) begin
                        errors++;
                        $display("[TB] FAIL pop_order: presented pc=%h inst=%h, expected pc=%h inst=%h",
                                 pc_o, inst_o, sb_head[63:32], sb_head[31:0]);
                    end
                end
            end
            if (flush_i) exp_q.delete();
            if (imem_req_o && imem_gnt_i) exp_q.push_back({imem_addr_o, memData(imem_addr_o)});
        end
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic nextCycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic applyStimulus(input logic stall, input logic flush, input logic [31:0] fpc);
        stall_i    = stall;
        flush_i    = flush;
        flush_pc_i = fpc;
    endtask

    task automatic checkOutput(input string name, input logic req, input logic [31:0] addr, pc, inst);
        @(negedge clk_i);
        checks++;
        if (imem_req_o !== req || imem_addr_o !== addr || pc_o !== pc || inst_o !== inst) begin
            errors++;
            $display("[TB] FAIL %s: got req=%b addr=%h pc=%h inst=%h, expected req=%b addr=%h pc=%h inst=%h",
                     name, imem_req_o, imem_addr_o, pc_o, inst_o, req, addr, pc, inst);
        end
    endtask

    task automatic doReset(input string name);
        rst_i = 1'b1;
        applyStimulus(1'b0, 1'b0, '0);
        hold_resp = 1'b0;
        use_override = 1'b0;
        nextCycle();
        checkOutput(name, 1'b0, RST_PC, RST_PC, NOP);
        nextCycle();
        rst_i = 1'b0;
    endtask

    function automatic void addRow(input logic stall, input logic req, input logic [31:0] addr, pc, inst);
        vec_t v;
        v.stall = stall;
        v.req   = req;
        v.addr  = addr;
        v.pc    = pc;
        v.inst  = inst;
        vecs.push_back(v);
    endfunction

    // Streaming with a zero-wait memory, then a 10-cycle stall and release.
    function automatic void buildTable();
        addRow(0, 1, RST_PC + 32'h00, RST_PC + 32'h00, NOP);
        addRow(0, 0, RST_PC + 32'h04, RST_PC + 32'h00, NOP);
        addRow(0, 1, RST_PC + 32'h04, RST_PC + 32'h00, memData(RST_PC + 32'h00));
        addRow(0, 0, RST_PC + 32'h08, RST_PC + 32'h04, NOP);
        addRow(0, 1, RST_PC + 32'h08, RST_PC + 32'h04, memData(RST_PC + 32'h04));
        addRow(0, 0, RST_PC + 32'h0C, RST_PC + 32'h08, NOP);
        addRow(1, 1, RST_PC + 32'h0C, RST_PC + 32'h08, memData(RST_PC + 32'h08));
        for (int i = 0; i < 9; i++)
            addRow(1, 0, RST_PC + 32'h10, RST_PC + 32'h08, memData(RST_PC + 32'h08));
        addRow(0, 0, RST_PC + 32'h10, RST_PC + 32'h08, memData(RST_PC + 32'h08));
        addRow(0, 1, RST_PC + 32'h10, RST_PC + 32'h0C, memData(RST_PC + 32'h0C));
        addRow(0, 0, RST_PC + 32'h14, RST_PC + 32'h10, NOP);
        addRow(0, 1, RST_PC + 32'h14, RST_PC + 32'h10, memData(RST_PC + 32'h10));
    endfunction

    initial begin : main
        buildTable();
        doReset("reset");

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].stall, 1'b0, '0);
            checkOutput($sformatf("stream_vec%0d", i), vecs[i].req, vecs[i].addr, vecs[i].pc, vecs[i].inst);
            nextCycle();
        end

        // Flush while a request is outstanding; the late response must be dropped.
        doReset("reset_flush_wait");
        hold_resp = 1'b1;
        checkOutput("fw_issue", 1, RST_PC, RST_PC, NOP);
        nextCycle();
        applyStimulus(0, 1, 32'h8000_0103);
        checkOutput("fw_flush", 0, RST_PC + 32'h4, RST_PC, NOP);
        nextCycle();
        applyStimulus(0, 0, '0);
        hold_resp = 1'b0;
        use_override = 1'b1;
        override_data = 32'hDEAD_BEEF;
        checkOutput("fw_discard", 0, 32'h8000_0100, 32'h8000_0100, NOP);
        nextCycle();
        use_override = 1'b0;
        checkOutput("fw_stale_rvalid", 0, 32'h8000_0100, 32'h8000_0100, NOP);
        nextCycle();
        checkOutput("fw_new_req", 1, 32'h8000_0100, 32'h8000_0100, NOP);
        nextCycle();
        checkOutput("fw_new_wait", 0, 32'h8000_0104, 32'h8000_0100, NOP);
        nextCycle();
        checkOutput("fw_new_data", 1, 32'h8000_0104, 32'h8000_0100, memData(32'h8000_0100));
        nextCycle();

        // Flush while stalled with a full FIFO.
        doReset("reset_flush_full");
        applyStimulus(1, 0, '0);
        for (int i = 0; i < 4; i++) nextCycle();
        checkOutput("ff_full", 0, RST_PC + 32'h8, RST_PC, memData(RST_PC));
        nextCycle();
        applyStimulus(1, 1, 32'h0000_1000);
        checkOutput("ff_flush", 0, RST_PC + 32'h8, RST_PC, memData(RST_PC));
        nextCycle();
        applyStimulus(1, 0, '0);
        checkOutput("ff_after", 1, 32'h0000_1000, 32'h0000_1000, NOP);
        nextCycle();
        applyStimulus(0, 0, '0);
        checkOutput("ff_wait", 0, 32'h0000_1004, 32'h0000_1000, NOP);
        nextCycle();
        checkOutput("ff_data", 1, 32'h0000_1004, 32'h0000_1000, memData(32'h0000_1000));
        nextCycle();

        // Flush coinciding with rvalid, then address wrap, then reset mid-WAIT.
        doReset("reset_flush_rvalid");
        checkOutput("fr_issue", 1, RST_PC, RST_PC, NOP);
        nextCycle();
        applyStimulus(0, 1, 32'h0000_2000);
        checkOutput("fr_flush", 0, RST_PC + 32'h4, RST_PC, NOP);
        nextCycle();
        applyStimulus(0, 0, '0);
        checkOutput("fr_redirect", 1, 32'h0000_2000, 32'h0000_2000, NOP);
        nextCycle();
        checkOutput("fr_no_stale", 0, 32'h0000_2004, 32'h0000_2000, NOP);
        nextCycle();
        checkOutput("fr_data", 1, 32'h0000_2004, 32'h0000_2000, memData(32'h0000_2000));
        nextCycle();
        applyStimulus(0, 1, 32'hFFFF_FFFC);
        nextCycle();
        applyStimulus(0, 0, '0);
        checkOutput("wrap_issue", 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, NOP);
        nextCycle();
        checkOutput("wrap_next", 0, 32'h0000_0000, 32'hFFFF_FFFC, NOP);
        nextCycle();
        checkOutput("wrap_data", 1, 32'h0000_0000, 32'hFFFF_FFFC, memData(32'hFFFF_FFFC));
        nextCycle();
        doReset("reset_mid_wait");
        checkOutput("rmw_issue", 1, RST_PC, RST_PC, NOP);
        nextCycle();
        checkOutput("rmw_wait", 0, RST_PC + 32'h4, RST_PC, NOP);
        nextCycle();
        checkOutput("rmw_data", 1, RST_PC + 32'h4, RST_PC, memData(RST_PC));
        nextCycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
